// File: rtl/nco_pkg.sv
// Shared widths, saturation limits and the I/Q pair type for the NCO
// cos/sin splitter.
package nco_pkg;

    localparam int DDS_W = 16;
    localparam int O_W   = 12;

    localparam logic signed [O_W-1:0] MAX_POS = {1'b0, {(O_W-1){1'b1}}};
    localparam logic signed [O_W-1:0] MIN_NEG = {1'b1, {(O_W-1){1'b0}}};

    typedef struct packed {
        logic signed [O_W-1:0] sin;
        logic signed [O_W-1:0] cos;
    } iq_t;

endpackage

// File: rtl/nco_sample_reduce.sv
// Combinational reduce / round / saturate / conjugate for one {sin, cos} pair.
// Rounding with saturation is built when NCO_ROUND_EN is defined.
module nco_sample_reduce
    import nco_pkg::*;
#(
    parameter int DDS_WIDTH = DDS_W,
    parameter int O_WIDTH   = O_W
) (
    input  logic [2*DDS_WIDTH-1:0] dds,
    input  logic                   conj,
    output iq_t                    pair,
    output logic                   sat
);

    localparam int LSB = DDS_WIDTH - O_WIDTH;

    logic [DDS_WIDTH-1:0] cos_f;
    logic [DDS_WIDTH-1:0] sin_f;
    logic [O_WIDTH-1:0]   cos_r;
    logic [O_WIDTH-1:0]   sin_r;
    logic                 cos_ov;
    logic                 sin_ov;
    logic                 unused_fields;

    assign cos_f = dds[DDS_WIDTH-1:0];
    assign sin_f = dds[2*DDS_WIDTH-1:DDS_WIDTH];
    assign unused_fields = ^{cos_f, sin_f};

    generate
`ifdef NCO_ROUND_EN
        if (LSB > 0) begin : g_round
            localparam logic [DDS_WIDTH:0] HALF = (DDS_WIDTH+1)'(1) << (LSB-1);
            logic [DDS_WIDTH:0] cos_s;
            logic [DDS_WIDTH:0] sin_s;

            // Adding a positive half-LSB can only overflow upward.
            assign cos_s  = {cos_f[DDS_WIDTH-1], cos_f} + HALF;
            assign sin_s  = {sin_f[DDS_WIDTH-1], sin_f} + HALF;
            assign cos_ov = cos_s[DDS_WIDTH] ^ cos_s[DDS_WIDTH-1];
            assign sin_ov = sin_s[DDS_WIDTH] ^ sin_s[DDS_WIDTH-1];
            assign cos_r  = cos_ov ? MAX_POS : cos_s[DDS_WIDTH-1:LSB];
            assign sin_r  = sin_ov ? MAX_POS : sin_s[DDS_WIDTH-1:LSB];
        end else begin : g_pass
            assign cos_ov = 1'b0;
            assign sin_ov = 1'b0;
            assign cos_r  = cos_f[DDS_WIDTH-1:LSB];
            assign sin_r  = sin_f[DDS_WIDTH-1:LSB];
        end
`else
        if (1) begin : g_trunc
            assign cos_ov = 1'b0;
            assign sin_ov = 1'b0;
            assign cos_r  = cos_f[DDS_WIDTH-1:LSB];
            assign sin_r  = sin_f[DDS_WIDTH-1:LSB];
        end
`endif
    endgenerate

    always_comb begin
        pair.cos = cos_r;
        pair.sin = sin_r;
        sat      = cos_ov | sin_ov;
        if (conj) begin
            if (sin_r == MIN_NEG) begin
                pair.sin = MAX_POS;
                sat      = 1'b1;
            end else begin
                pair.sin = -sin_r;
            end
        end
    end

endmodule

// File: rtl/nco_cos_sin_axis.sv
// Registered AXI-Stream NCO cos/sin splitter with one-entry skid buffer.
// Define NCO_ROUND_EN for round-half-up reduction with saturation.
module nco_cos_sin_axis
    import nco_pkg::*;
#(
    parameter int DDS_WIDTH = DDS_W,
    parameter int O_WIDTH   = O_W,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2*DDS_WIDTH-1:0] s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   conj,
    input  logic                   m_ready,
    output logic [O_WIDTH-1:0]     NCO_cos,
    output logic [O_WIDTH-1:0]     NCO_sin,
    output logic                   NCO_valid,
    output logic [CNT_WIDTH-1:0]   sample_cnt,
    output logic                   sat_flag
);

    iq_t                  in_iq;
    iq_t                  out_q;
    iq_t                  skid_q;
    logic                 in_sat;
    logic                 out_vld;
    logic                 skid_vld;
    logic                 skid_vld_nx;
    logic                 rdy_q;
    logic                 acc;
    logic                 cons;
    logic                 load;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 sat_q;

    nco_sample_reduce #(
        .DDS_WIDTH (DDS_WIDTH),
        .O_WIDTH   (O_WIDTH)
    ) u_reduce (
        .dds  (s_tdata),
        .conj (conj),
        .pair (in_iq),
        .sat  (in_sat)
    );

    assign acc  = s_tvalid & rdy_q;
    assign cons = out_vld & m_ready;
    assign load = ~out_vld | cons;

    // Skid holds a sample whenever the output cannot take the newest one.
    always_comb begin
        skid_vld_nx = skid_vld;
        if (load) begin
            skid_vld_nx = skid_vld & acc;
        end else if (acc) begin
            skid_vld_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            skid_q   <= '0;
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            rdy_q    <= ~skid_vld_nx;
            skid_vld <= skid_vld_nx;
            sat_q    <= sat_q | (acc & in_sat);
            if (cons) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            if (load) begin
                if (skid_vld) begin
                    out_q   <= skid_q;
                    out_vld <= 1'b1;
                end else begin
                    out_vld <= acc;
                    if (acc) begin
                        out_q <= in_iq;
                    end
                end
            end
            if (acc & skid_vld_nx) begin
                skid_q <= in_iq;
            end
        end
    end

    assign s_tready   = rdy_q;
    assign NCO_cos    = out_q.cos;
    assign NCO_sin    = out_q.sin;
    assign NCO_valid  = out_vld;
    assign sample_cnt = cnt_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_nco_cos_sin_axis.sv
// Randomized bench for nco_cos_sin_axis against a queue-based reference
// model of the stream behaviour (DDS_WIDTH=16, O_WIDTH=12, CNT_WIDTH=4).
module tb_nco_cos_sin_axis;

    localparam int DW = 16;
    localparam int OW = 12;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2*DW-1:0] s_tdata = '0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic            conj = 1'b0;
    logic            m_ready = 1'b0;
    logic [OW-1:0]   NCO_cos;
    logic [OW-1:0]   NCO_sin;
    logic            NCO_valid;
    logic [CW-1:0]   sample_cnt;
    logic            sat_flag;

    nco_cos_sin_axis #(
        .DDS_WIDTH (DW),
        .O_WIDTH   (OW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .conj       (conj),
        .m_ready    (m_ready),
        .NCO_cos    (NCO_cos),
        .NCO_sin    (NCO_sin),
        .NCO_valid  (NCO_valid),
        .sample_cnt (sample_cnt),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int s;
    } pair_t;

    pair_t    q[$];
    int       m_cnt;
    bit       m_sat;
    bit       prev_stall;
    logic [OW-1:0] prev_c;
    logic [OW-1:0] prev_s;
    int       n_tests;
    int       n_fail;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: integer scaling by 2^(DW-OW), optional round-half-up.
    function automatic int reduce(input logic [15:0] f, output bit sat);
        int x;
        x   = int'($signed(f));
        sat = 1'b0;
`ifdef NCO_ROUND_EN
        x = (x + 8) >>> 4;
        if (x > 2047) begin
            x   = 2047;
            sat = 1'b1;
        end
`else
        x = x >>> 4;
`endif
        return x;
    endfunction

    function automatic pair_t model(input logic [15:0] c, input logic [15:0] s,
                                    input bit cj, output bit sat);
        pair_t p;
        bit    sc;
        bit    ss;
        p.c = reduce(c, sc);
        p.s = reduce(s, ss);
        sat = sc | ss;
        if (cj) begin
            p.s = -p.s;
            if (p.s > 2047) begin
                p.s = 2047;
                sat = 1'b1;
            end
        end
        return p;
    endfunction

    task automatic step(input bit v, input logic [15:0] c, input logic [15:0] s,
                        input bit cj, input bit mr, output bit acc);
        pair_t p;
        bit    sat;
        @(negedge clk);
        check("valid", NCO_valid, q.size() > 0);
        check("tready", s_tready, q.size() < 2);
        check("cnt", sample_cnt, m_cnt % 16);
        check("sat", sat_flag, m_sat);
        if (prev_stall) begin
            check("hold_cos", NCO_cos, prev_c);
            check("hold_sin", NCO_sin, prev_s);
        end
        s_tvalid = v;
        s_tdata  = {s, c};
        conj     = cj;
        m_ready  = mr;
        acc      = v && s_tready;
        prev_stall = NCO_valid && !mr;
        prev_c     = NCO_cos;
        prev_s     = NCO_sin;
        if (NCO_valid && mr) begin
            if (q.size() == 0) begin
                check("underflow", q.size(), 1);
            end else begin
                check("cos", NCO_cos, q[0].c & 32'hFFF);
                check("sin", NCO_sin, q[0].s & 32'hFFF);
                void'(q.pop_front());
                m_cnt++;
            end
        end
        if (acc) begin
            p = model(c, s, cj, sat);
            q.push_back(p);
            m_sat = m_sat | sat;
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] c,
                              input logic [31:0] s);
        @(posedge clk);
        #1;
        check({tag, "_cos"}, NCO_cos, c);
        check({tag, "_sin"}, NCO_sin, s);
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt      = 0;
        m_sat      = 1'b0;
        prev_stall = 1'b0;
    endtask

    logic [15:0] specials [5] = '{16'h8000, 16'h7FFF, 16'h7FF8, 16'h0000, 16'hFFFF};

    function automatic logic [15:0] rnd_field();
        if ($urandom_range(3) == 0) begin
            return specials[$urandom_range(4)];
        end
        return 16'($urandom);
    endfunction

    initial begin
        bit acc;
        bit saw_full;
        int sent;
        n_tests = 0;
        n_fail  = 0;
        model_reset();

        #23;
        check("rst_valid", NCO_valid, 0);
        check("rst_tready", s_tready, 0);
        check("rst_cnt", sample_cnt, 0);
        check("rst_sat", sat_flag, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Directed values with known answers.
        step(1, 16'h1238, 16'h0F00, 0, 1, acc);
`ifdef NCO_ROUND_EN
        expect_out("t1", 32'h124, 32'h0F0);
`else
        expect_out("t1", 32'h123, 32'h0F0);
`endif
        step(1, 16'h0000, 16'h7FF8, 0, 1, acc);
        expect_out("t2", 32'h000, 32'h7FF);
        step(0, 16'h0, 16'h0, 0, 1, acc);
        check("t1_cnt", sample_cnt, 1);
`ifdef NCO_ROUND_EN
        check("t2_sat", sat_flag, 1);
`else
        check("t2_sat", sat_flag, 0);
`endif
        step(1, 16'h0000, 16'h0100, 1, 1, acc);
        expect_out("t3b", 32'h000, 32'hFF0);
        step(1, 16'h0000, 16'h8000, 1, 1, acc);
        expect_out("t3a", 32'h000, 32'h7FF);
        step(0, 16'h0, 16'h0, 0, 1, acc);
        check("t3_sat", sat_flag, 1);

        // Stall with a backlog: skid must fill and nothing may be lost.
        sent     = 0;
        saw_full = 1'b0;
        for (int cyc = 0; cyc < 60 && sent < 8; cyc++) begin
            step(1, 16'(sent * 16'h0110 + 16'h0020), 16'(16'h4000 - sent * 16'h0230),
                 sent[0], cyc >= 3, acc);
            if (!s_tready) saw_full = 1'b1;
            if (acc) sent++;
        end
        check("t4_sent", sent, 8);
        check("t4_skid_full", saw_full, 1);
        for (int i = 0; i < 4; i++) step(0, 16'h0, 16'h0, 0, 1, acc);
        check("t4_drain", q.size(), 0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3) != 0, rnd_field(), rnd_field(),
                 $urandom_range(1), $urandom_range(2) != 0, acc);
        end
        for (int i = 0; i < 4; i++) step(0, 16'h0, 16'h0, 0, 1, acc);

        // Reset with both output and skid occupied.
        step(1, 16'h1110, 16'h2220, 0, 0, acc);
        step(1, 16'h3330, 16'h4440, 0, 0, acc);
        step(1, 16'h5550, 16'h6660, 0, 0, acc);
        check("t6_full", q.size(), 2);
        @(negedge clk);
        s_tvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", NCO_valid, 0);
        check("t6_cnt", sample_cnt, 0);
        check("t6_tready", s_tready, 0);
        check("t6_sat", sat_flag, 0);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(0, 16'h0, 16'h0, 0, 1, acc);
        step(1, 16'h7770, 16'h0880, 0, 1, acc);
        expect_out("t6_first", 32'h777, 32'h088);

        // Counter wrap after 17 handshakes from zero.
        for (int i = 0; i < 16; i++) step(1, rnd_field(), rnd_field(), 0, 1, acc);
        for (int i = 0; i < 3; i++) step(0, 16'h0, 16'h0, 0, 1, acc);
        check("t5_wrap", sample_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/nco_cos_sin_axis.md
Name: nco_cos_sin_axis

Overview:
- Registered, flow-controlled successor to the combinational NCO cos/sin splitter.
- Accepts packed DDS output {sin, cos} on an AXI-Stream slave and returns backpressure via s_tready.
- Reduces each DDS field to O_WIDTH signed bits, optionally conjugates (negates sin), and presents a registered I/Q pair with valid/ready.
- Sits between the DDS IP and the mixer/Costas loop. The mixer may stall, so the DDS stream is never dropped.

Parameters:
- DDS_WIDTH, 16: width of each signed field in s_tdata; must be >= O_WIDTH.
- O_WIDTH, 12: output sample width, signed.
- CNT_WIDTH, 16: width of the output sample counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_tdata  in  2*DDS_WIDTH  [DDS_WIDTH-1:0]=cos, [2*DDS_WIDTH-1:DDS_WIDTH]=sin, both two's complement
- s_tvalid  in  1  input sample valid
- s_tready  out  1  block can accept a sample
- conj  in  1  1 = output sin negated; sampled with each accepted input
- m_ready  in  1  downstream accepts output
- NCO_cos  out  O_WIDTH  signed cos output
- NCO_sin  out  O_WIDTH  signed sin output
- NCO_valid  out  1  output pair valid
- sample_cnt  out  CNT_WIDTH  count of completed output handshakes
- sat_flag  out  1  sticky; set when any saturation occurs

Behaviour:
- Reset (async assert, sync release): NCO_cos=0, NCO_sin=0, NCO_valid=0, s_tready=0 during reset and 1 from the first clock after release, sample_cnt=0, sat_flag=0, skid empty.
- Handshakes:
  - Input accepted when s_tvalid & s_tready.
  - Output consumed when NCO_valid & m_ready.
  - NCO_cos/NCO_sin/NCO_valid are held stable while NCO_valid & !m_ready.
- Datapath:
  - Output register plus one-entry skid register, both holding processed O_WIDTH pairs.
  - s_tready is a registered signal equal to "skid empty"; it carries no combinational path from m_ready.
- Latency: an accepted sample appears on the outputs on the next clock edge when the output register is free or being consumed.
- Update rules, per cycle:
  - Output register loads when it is empty or being consumed. It loads from the skid if the skid is full, else from the accepted input.
  - If the skid supplies the output while a new input is accepted in the same cycle, the input goes into the skid (ordering preserved).
  - If the output is stalled and an input is accepted, the input goes to the skid and s_tready drops next cycle.
  - Skid full and output consumed: skid moves to output; s_tready rises next cycle.
  - No sample is ever dropped or duplicated. Order is strict FIFO.
- Width reduction (default): truncation; take bits [DDS_WIDTH-1 : DDS_WIDTH-O_WIDTH] of each field. When DDS_WIDTH==O_WIDTH, the field passes through unchanged.
- Conjugate:
  - Applied after reduction: sin_out = -sin.
  - -(-2^(O_WIDTH-1)) saturates to 2^(O_WIDTH-1)-1 and sets sat_flag.
  - conj has no effect on cos.
- sample_cnt:
  - Increments on each output handshake.
  - Wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- sat_flag: sticky until reset.
- Reset mid-operation: all stored samples are discarded immediately and outputs return to reset values asynchronously.

Optional Feature:
- Macro: NCO_ROUND_EN.
- Defined:
  - Reduction is round-half-up: add 1 at bit position DDS_WIDTH-O_WIDTH-1, then take the top O_WIDTH bits.
  - Positive overflow saturates to 2^(O_WIDTH-1)-1 and sets sat_flag.
  - Rounding precedes conj.
  - Inactive when DDS_WIDTH==O_WIDTH.
- Undefined: plain truncation; no saturation from reduction.
- Latency and handshakes are identical in both builds.

Decomposition:
- Package nco_pkg holds:
  - field-extraction and saturation-limit constants derived from the widths (MAX_POS, MIN_NEG);
  - a packed iq_t struct {sin, cos} of O_WIDTH each, used for the skid and output registers.
- One natural sub-module, nco_sample_reduce: combinational reduce/round/saturate/negate for one pair. It outputs the pair plus a sat pulse and is instantiated once on the input path.

Test Plan (DDS_WIDTH=16, O_WIDTH=12, CNT_WIDTH=4):
1. m_ready=1; input cos=0x1238, sin=0x0F00, conj=0 -> next cycle NCO_cos=0x123 (0x124 with NCO_ROUND_EN), NCO_sin=0x0F0, NCO_valid=1, sample_cnt increments to 1.
2. Input sin=0x7FF8: without macro -> 0x7FF, sat_flag=0. With NCO_ROUND_EN -> 0x7FF, sat_flag=1.
3. conj=1, sin=0x8000 -> NCO_sin=0x7FF, sat_flag=1. conj=1, sin=0x0100 -> NCO_sin=0xFF0.
4. Stream 8 samples with s_tvalid=1 while m_ready is held 0 for 3 cycles -> s_tready=0 after the skid fills, outputs stable while stalled, all 8 received in order with none lost.
5. 17 consecutive handshakes -> sample_cnt wraps 15->0 and reads 1 at the end.
6. Assert rst_n=0 with both the skid and output register full -> NCO_valid=0 and sample_cnt=0 immediately; after release, the first new sample emerges with latency 1.
